upc_loop_monitor: RTL

//  Consumer of the per-loop cosim probe signals (loop handshake, HLS FSM state, iteration

---
 rtl/upc_loop_pkg.sv | 29 ++
 rtl/upc_sat_counter.sv | 34 +++
 rtl/upc_loop_monitor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/upc_loop_pkg.sv
// Shared types for the loop monitor: lifecycle states and the saturating-counter step helper.
package upc_loop_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      QUIT_PEND = 2'd2,
      EXIT      = 2'd3
   } loop_state_e;

   typedef enum logic [1:0] {
      CNT_HOLD = 2'd0,
      CNT_UP   = 2'd1,
      CNT_DOWN = 2'd2
   } cnt_op_e;

   // Decide one counter step: simultaneous up/down cancels, and both ends stick.
   function automatic cnt_op_e sat_op(input logic inc, input logic dec,
                                      input logic at_max, input logic at_zero);
      cnt_op_e op;
      op = CNT_HOLD;
      if (inc && !dec && !at_max)
         op = CNT_UP;
      else if (dec && !inc && !at_zero)
         op = CNT_DOWN;
      return op;
   endfunction

endpackage

// File: rtl/upc_sat_counter.sv
// Saturating up/down counter with synchronous clear and a freeze that overrides everything.
module upc_sat_counter
   import upc_loop_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   input  logic         clr,
   input  logic         frz,
   output logic [W-1:0] count
);

   cnt_op_e op;

   assign op = sat_op(inc, dec, &count, count == '0);

   // Count register: freeze wins over clear, and clear wins over counting.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (!frz) begin
         if (clr)
            count <= '0;
         else if (op == CNT_UP)
            count <= count + W'(1);
         else if (op == CNT_DOWN)
            count <= count - W'(1);
      end
   end

endmodule

// File: rtl/upc_loop_monitor.sv
// Loop lifecycle monitor for cosim probes: tracks RUN/QUIT_PEND/EXIT, counts iterations and
// cycles, and raises sticky protocol-error flags.
//
//  state     | meaning
//  IDLE      | no loop invocation in progress
//  RUN       | loop running, iteration/quit events honoured
//  QUIT_PEND | quit seen with quit_at_end, waiting for the current iteration to end
//  EXIT      | single cycle: publish trip count, bump loop count, clear per-invocation state
module upc_loop_monitor
   import upc_loop_pkg::*;
#(
   parameter int FSM_WIDTH = 2,
   parameter int CNT_W     = 32,
   parameter int OPEN_W    = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 loop_start,
   input  logic                 loop_ready,
   input  logic                 loop_done,
   input  logic                 loop_continue,
   input  logic [FSM_WIDTH-1:0] cur_state,
   input  logic [FSM_WIDTH-1:0] iter_start_state,
   input  logic                 iter_start_enable,
   input  logic                 iter_start_block,
   input  logic [FSM_WIDTH-1:0] iter_end_state,
   input  logic                 iter_end_enable,
   input  logic                 iter_end_block,
   input  logic [FSM_WIDTH-1:0] quit_state,
   input  logic                 quit_enable,
   input  logic                 quit_block,
   input  logic                 quit_at_end,
   input  logic                 finish,
   output logic                 loop_active,
   output logic                 iter_start_pulse,
   output logic                 iter_end_pulse,
   output logic                 loop_exit_pulse,
   output logic [CNT_W-1:0]     iter_count,
   output logic [CNT_W-1:0]     trip_count,
   output logic [CNT_W-1:0]     loop_count,
   output logic [CNT_W-1:0]     active_cycles,
   output logic [OPEN_W-1:0]    open_iters,
   output logic                 report_valid,
   output logic                 err_unbalanced,
   output logic                 err_restart
);

   loop_state_e state, state_next;
   logic        active, frozen, in_exit;
   logic        ev_s, ev_e, ev_q;
   logic        unused_ready;

   // loop_ready only gates cycle accounting upstream; it carries no lifecycle meaning here.
   assign unused_ready = loop_ready;

   assign active  = (state == RUN) || (state == QUIT_PEND);
   assign in_exit = (state == EXIT);
   // The finish cycle itself already freezes, so the report snapshot is the pre-finish state.
   assign frozen  = finish || report_valid;

   assign ev_s = active && (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
   assign ev_e = active && (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
   assign ev_q = active && (cur_state == quit_state) && quit_enable && !quit_block;

   assign loop_active = active;

   // Next-state logic for the loop lifecycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (loop_start) state_next = RUN;
         RUN: begin
            if (loop_done || (ev_q && (!quit_at_end || ev_e)))
               state_next = EXIT;
            else if (ev_q)
               state_next = QUIT_PEND;
         end
         QUIT_PEND: if (loop_done || ev_e) state_next = EXIT;
         EXIT:      state_next = loop_continue ? RUN : IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // State register, held once the report is taken.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else if (!frozen)
         state <= state_next;
   end

   // Event pulses, trip-count capture and sticky flags.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         iter_start_pulse <= 1'b0;
         iter_end_pulse   <= 1'b0;
         loop_exit_pulse  <= 1'b0;
         trip_count       <= '0;
         report_valid     <= 1'b0;
         err_unbalanced   <= 1'b0;
         err_restart      <= 1'b0;
      end else begin
         report_valid <= report_valid || finish;
         if (frozen) begin
            iter_start_pulse <= 1'b0;
            iter_end_pulse   <= 1'b0;
            loop_exit_pulse  <= 1'b0;
         end else begin
            iter_start_pulse <= ev_s;
            iter_end_pulse   <= ev_e;
            loop_exit_pulse  <= (state_next == EXIT);
            if (in_exit)
               trip_count <= iter_count;
            if (ev_e && !ev_s && (open_iters == '0))
               err_unbalanced <= 1'b1;
            if (active && loop_start)
               err_restart <= 1'b1;
         end
      end
   end

   upc_sat_counter #(.W(CNT_W)) u_iter_count (
      .clock(clock), .reset(reset), .inc(ev_e), .dec(1'b0),
      .clr(in_exit), .frz(frozen), .count(iter_count)
   );

   upc_sat_counter #(.W(CNT_W)) u_loop_count (
      .clock(clock), .reset(reset), .inc(in_exit), .dec(1'b0),
      .clr(1'b0), .frz(frozen), .count(loop_count)
   );

   upc_sat_counter #(.W(CNT_W)) u_active_cycles (
      .clock(clock), .reset(reset), .inc(active), .dec(1'b0),
      .clr(1'b0), .frz(frozen), .count(active_cycles)
   );

   upc_sat_counter #(.W(OPEN_W)) u_open_iters (
      .clock(clock), .reset(reset), .inc(ev_s), .dec(ev_e),
      .clr(in_exit), .frz(frozen), .count(open_iters)
   );

endmodule
